sigmoid_activation: RTL and testbench

- Downstream of `mvm`; consumes its packed signed dot-product vector and produces the layer's activation vector.
- Applies a fixed-point piecewise-linear sigmoid (PLAN approximation) to each element.
- Processes LANES elements per cycle through a 2-stage pipeline.
- Uses the same start/valid pulse handshake as `mvm`; the output feeds the next layer's vector input and the backprop error stage.

---
 rtl/nn_pkg.sv | 38 +++
 rtl/plan_sigmoid.sv | 79 +++++++
 rtl/sigmoid_activation.sv | 115 +++++++++++
 tb/tb_sigmoid_activation.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath: sizing helper, FSM and
// PLAN segment encodings, and the PLAN sigmoid constants as fractions of ONE.
package nn_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} sig_state_e;
  typedef enum logic [1:0] {SEG_S0, SEG_S1, SEG_S2, SEG_SAT} plan_seg_e;

  // Breakpoints and offsets are num / 2^den_sh of ONE; slopes are right shifts.
  localparam int unsigned PLAN_SAT_NUM    = 5;
  localparam int unsigned PLAN_SAT_SH     = 0;
  localparam int unsigned PLAN_S2_NUM     = 19;
  localparam int unsigned PLAN_S2_SH      = 3;
  localparam int unsigned PLAN_S1_NUM     = 1;
  localparam int unsigned PLAN_S1_SH      = 0;
  localparam int unsigned PLAN_OFF_S0_NUM = 1;
  localparam int unsigned PLAN_OFF_S0_SH  = 1;
  localparam int unsigned PLAN_OFF_S1_NUM = 5;
  localparam int unsigned PLAN_OFF_S1_SH  = 3;
  localparam int unsigned PLAN_OFF_S2_NUM = 27;
  localparam int unsigned PLAN_OFF_S2_SH  = 5;
  localparam int unsigned PLAN_SLOPE_S0_SH = 2;
  localparam int unsigned PLAN_SLOPE_S1_SH = 3;
  localparam int unsigned PLAN_SLOPE_S2_SH = 5;

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned frac_of_one(input int unsigned num,
                                              input int unsigned den_sh,
                                              input int unsigned frac);
    return (num << frac) >> den_sh;
  endfunction

endpackage

// File: rtl/plan_sigmoid.sv
// One PLAN sigmoid lane: stage 1 computes |x| and the segment, stage 2 applies
// the segment's slope/offset, mirrors for negative inputs and saturates.
module plan_sigmoid
  import nn_pkg::*;
#(
  parameter int INPUT_WIDTH  = 20,
  parameter int INPUT_FRAC   = 8,
  parameter int OUTPUT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic signed [INPUT_WIDTH-1:0]  x,
  output logic        [OUTPUT_WIDTH-1:0] y
);

  // a_p1 only needs to cover the non-saturating range (< 5*ONE < 8*ONE).
  localparam int A_W    = INPUT_FRAC + 3;
  localparam int CW     = ((INPUT_WIDTH > A_W) ? INPUT_WIDTH : A_W) + 1;
  localparam int OUT_SH = INPUT_FRAC - OUTPUT_WIDTH;

  localparam logic [CW-1:0]  TH_SAT  = CW'(frac_of_one(PLAN_SAT_NUM, PLAN_SAT_SH, INPUT_FRAC));
  localparam logic [CW-1:0]  TH_S2   = CW'(frac_of_one(PLAN_S2_NUM, PLAN_S2_SH, INPUT_FRAC));
  localparam logic [CW-1:0]  TH_S1   = CW'(frac_of_one(PLAN_S1_NUM, PLAN_S1_SH, INPUT_FRAC));
  localparam logic [A_W-1:0] ONE_Y   = A_W'(frac_of_one(1, 0, INPUT_FRAC));
  localparam logic [A_W-1:0] OFF_S0  = A_W'(frac_of_one(PLAN_OFF_S0_NUM, PLAN_OFF_S0_SH, INPUT_FRAC));
  localparam logic [A_W-1:0] OFF_S1  = A_W'(frac_of_one(PLAN_OFF_S1_NUM, PLAN_OFF_S1_SH, INPUT_FRAC));
  localparam logic [A_W-1:0] OFF_S2  = A_W'(frac_of_one(PLAN_OFF_S2_NUM, PLAN_OFF_S2_SH, INPUT_FRAC));
  localparam logic [A_W-1:0] OUT_MAX = A_W'((1 << OUTPUT_WIDTH) - 1);

  // Negating the most negative value leaves the MSB set; that case saturates.
  function automatic logic [INPUT_WIDTH-1:0] abs_sat(input logic signed [INPUT_WIDTH-1:0] v);
    logic [INPUT_WIDTH-1:0] mag;
    mag = v[INPUT_WIDTH-1] ? unsigned'(-v) : unsigned'(v);
    if (mag[INPUT_WIDTH-1]) mag = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
    return mag;
  endfunction

  function automatic logic [OUTPUT_WIDTH-1:0] sat_out(input logic [A_W-1:0] yq);
    logic [A_W-1:0] ys;
    ys = yq >> OUT_SH;
    if (ys > OUT_MAX) return '1;
    return ys[OUTPUT_WIDTH-1:0];
  endfunction

  logic [CW-1:0]  a_ext;
  plan_seg_e      seg;
  logic [A_W-1:0] a_p1;
  logic           sign_p1;
  plan_seg_e      seg_p1;
  logic [A_W-1:0] y_q;

  always_comb begin
    a_ext = CW'(abs_sat(x));
    if (a_ext >= TH_SAT)     seg = SEG_SAT;
    else if (a_ext >= TH_S2) seg = SEG_S2;
    else if (a_ext >= TH_S1) seg = SEG_S1;
    else                     seg = SEG_S0;
  end

  // Stage 1 -> stage 2 boundary
  always_ff @(posedge clk) begin
    a_p1    <= A_W'(a_ext);
    sign_p1 <= x[INPUT_WIDTH-1];
    seg_p1  <= seg;
  end

  always_comb begin
    y_q = ONE_Y;
    case (seg_p1)
      SEG_S0:  y_q = (a_p1 >> PLAN_SLOPE_S0_SH) + OFF_S0;
      SEG_S1:  y_q = (a_p1 >> PLAN_SLOPE_S1_SH) + OFF_S1;
      SEG_S2:  y_q = (a_p1 >> PLAN_SLOPE_S2_SH) + OFF_S2;
      default: y_q = ONE_Y;
    endcase
    if (sign_p1) y_q = ONE_Y - y_q;
  end

  assign y = sat_out(y_q);

endmodule

// File: rtl/sigmoid_activation.sv
// Vector sigmoid activation: buffers the upstream vector on start, streams it
// LANES elements per cycle through plan_sigmoid lanes and writes results back.
module sigmoid_activation
  import nn_pkg::*;
#(
  parameter int VECTOR_SIZE  = 20,
  parameter int INPUT_WIDTH  = 20,
  parameter int INPUT_FRAC   = 8,
  parameter int OUTPUT_WIDTH = 8,
  parameter int LANES        = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [VECTOR_SIZE*INPUT_WIDTH-1:0]  in_vector,
  output logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] out_vector,
  output logic                                valid,
  output logic                                busy
);

  localparam int IDX_W = log2(VECTOR_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - LANES);
  localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);

  if ((VECTOR_SIZE % LANES) != 0 || INPUT_FRAC < OUTPUT_WIDTH) begin : g_illegal
    $error("sigmoid_activation: need VECTOR_SIZE %% LANES == 0 and INPUT_FRAC >= OUTPUT_WIDTH");
  end

  sig_state_e state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, idx_p1;
  logic capture, issue, vld_p1, last_p1;

  logic signed [INPUT_WIDTH-1:0]  in_buf  [VECTOR_SIZE];
  logic        [OUTPUT_WIDTH-1:0] out_mem [VECTOR_SIZE];
  logic signed [INPUT_WIDTH-1:0]  lane_x  [LANES];
  logic        [OUTPUT_WIDTH-1:0] lane_y  [LANES];

  // valid is part of busy, so a start in the valid cycle is ignored as well.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !valid) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx == LAST_IDX) state_nxt = ST_DRAIN;
        else                 idx_nxt   = idx + STEP;
      end
      ST_DRAIN: begin
        if (vld_p1 && last_p1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign issue = (state == ST_RUN);
  assign busy  = (state != ST_IDLE) || valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      vld_p1  <= issue;
      last_p1 <= issue && (idx == LAST_IDX);
      valid   <= vld_p1 && last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < VECTOR_SIZE; i++)
        in_buf[i] <= in_vector[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
    idx_p1 <= idx;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_x[l] = in_buf[idx + IDX_W'(l)];
    plan_sigmoid #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .INPUT_FRAC  (INPUT_FRAC),
      .OUTPUT_WIDTH(OUTPUT_WIDTH)
    ) u_plan (
      .clk(clk),
      .x  (lane_x[l]),
      .y  (lane_y[l])
    );
  end

  // Stage 2 boundary: results land in their slots; other slots keep old values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VECTOR_SIZE; i++) out_mem[i] <= '0;
    end else if (vld_p1) begin
      for (int l = 0; l < LANES; l++) out_mem[idx_p1 + IDX_W'(l)] <= lane_y[l];
    end
  end

  for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_out
    assign out_vector[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = out_mem[i];
  end

endmodule

// File: tb/tb_sigmoid_activation.sv
// Bench for sigmoid_activation: directed and random vectors checked against a
// plain-arithmetic PLAN sigmoid model, plus handshake, latency and reset cases.
module tb_sigmoid_activation;

  localparam int VS = 20;
  localparam int IW = 20;
  localparam int FR = 8;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, start4 = 1'b0;
  logic [VS*IW-1:0] in_vec = '0, in_vec4 = '0;
  logic [VS*OW-1:0] out_vec, out_vec4;
  logic valid, valid4, busy, busy4;

  always #5 clk = ~clk;

  sigmoid_activation #(.VECTOR_SIZE(VS), .INPUT_WIDTH(IW), .INPUT_FRAC(FR),
                       .OUTPUT_WIDTH(OW), .LANES(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_vector(in_vec),
    .out_vector(out_vec), .valid(valid), .busy(busy));

  sigmoid_activation #(.VECTOR_SIZE(VS), .INPUT_WIDTH(IW), .INPUT_FRAC(FR),
                       .OUTPUT_WIDTH(OW), .LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_vector(in_vec4),
    .out_vector(out_vec4), .valid(valid4), .busy(busy4));

  int checks = 0, passed = 0, fails = 0;
  int xv[VS];
  int lat, bc, vc, first_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sigmoid approximation straight from the segment table.
  function automatic int model(input int x);
    int one, a, y;
    one = 1 << FR;
    a = (x < 0) ? -x : x;
    if (x == -(1 << (IW-1))) a = (1 << (IW-1)) - 1;
    if (a >= 5*one)           y = one;
    else if (8*a >= 19*one)   y = a/32 + 27*one/32;
    else if (a >= one)        y = a/8 + 5*one/8;
    else                      y = a/4 + one/2;
    if (x < 0) y = one - y;
    y = y / (1 << (FR-OW));
    if (y > (1 << OW) - 1) y = (1 << OW) - 1;
    return y;
  endfunction

  function automatic logic [VS*IW-1:0] pack_vec();
    logic [VS*IW-1:0] v;
    for (int i = 0; i < VS; i++) v[i*IW +: IW] = IW'(xv[i]);
    return v;
  endfunction

  function automatic int rand_x();
    int pts[6] = '{255, 256, 607, 608, 1279, 1280};
    int s;
    s = ($urandom_range(0, 1) == 0) ? 1 : -1;
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW-1));
      1:       return int'($urandom_range(0, 3200)) - 1600;
      2:       return s * pts[$urandom_range(0, 5)];
      default: return s * int'($urandom_range(0, 300));
    endcase
  endfunction

  function automatic logic [OW-1:0] elem(input bit use4, input int i);
    return use4 ? out_vec4[i*OW +: OW] : out_vec[i*OW +: OW];
  endfunction

  task automatic check_outputs(input string tag, input bit use4);
    for (int i = 0; i < VS; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(elem(use4, i)), model(xv[i]));
  endtask

  // Entered at a negedge; start is sampled on the next rising edge. Returns at
  // the negedge where valid is seen (or after the cycle budget runs out).
  task automatic run_vec(input bit use4, output int lat_o, output int busy_o);
    bit v, b;
    if (use4) begin in_vec4 = pack_vec(); start4 = 1'b1; end
    else      begin in_vec  = pack_vec(); start  = 1'b1; end
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
    for (int k = 0; k < VS; k++) begin
      in_vec[k*IW +: IW]  = IW'($urandom);
      in_vec4[k*IW +: IW] = IW'($urandom);
    end
    lat_o = 1; busy_o = 0;
    while (lat_o < 100) begin
      v = use4 ? valid4 : valid;
      b = use4 ? busy4 : busy;
      busy_o += int'(b);
      if (v) break;
      @(negedge clk);
      lat_o++;
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("reset_out", 32'(out_vec != '0), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_out4", 32'(out_vec4 != '0), 0);
    check("reset_busy4", 32'(busy4), 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed segment coverage
    xv = '{0, 128, 256, -256, 608, 1280, -1280, -524288, 0, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_vec(0, lat, bc);
    check("a_latency", lat, 22);
    check("a_busy_cycles", bc, 22);
    check_outputs("a_out", 0);
    check("a_lit0", 32'(elem(0, 0)), 128);
    check("a_lit1", 32'(elem(0, 1)), 160);
    check("a_lit2", 32'(elem(0, 2)), 192);
    check("a_lit3", 32'(elem(0, 3)), 64);
    check("a_lit5", 32'(elem(0, 5)), 255);
    check("a_lit6", 32'(elem(0, 6)), 0);
    check("a_lit7", 32'(elem(0, 7)), 0);
    check("a_lit19", 32'(elem(0, 19)), 128);
    @(negedge clk);
    check("a_valid_single", 32'(valid), 0);
    check("a_busy_done", 32'(busy), 0);

    // Back-to-back start in the cycle after valid
    for (int i = 0; i < VS; i++) xv[i] = -256;
    run_vec(0, lat, bc);
    check("b2b_latency", lat, 22);
    check_outputs("b2b_out", 0);
    check("b2b_lit", 32'(elem(0, 10)), 64);
    repeat (10) @(negedge clk);
    check("hold_valid", 32'(valid), 0);
    check_outputs("hold_out", 0);

    // mvm-style vector with a second start while busy
    for (int i = 0; i < VS; i++) xv[i] = 815 + 15*i;
    in_vec = pack_vec(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vc = 0; bc = 0; first_v = 0;
    for (int n = 1; n <= 60; n++) begin
      bc += int'(busy);
      if (valid) begin
        vc++;
        if (first_v == 0) first_v = n;
      end
      if (n == 5) begin
        start = 1'b1;
        for (int k = 0; k < VS; k++) in_vec[k*IW +: IW] = IW'($urandom);
      end
      if (n == 6) start = 1'b0;
      @(negedge clk);
    end
    check("mvm_latency", first_v, 22);
    check("mvm_valid_count", vc, 1);
    check("mvm_busy_cycles", bc, 22);
    check("mvm_lit0", 32'(elem(0, 0)), 241);
    check("mvm_lit19", 32'(elem(0, 19)), 250);
    check_outputs("mvm_out", 0);

    // Random vectors
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < VS; i++) xv[i] = rand_x();
      run_vec(0, lat, bc);
      check($sformatf("rnd%0d_latency", r), lat, 22);
      check_outputs($sformatf("rnd%0d_out", r), 0);
      @(negedge clk);
    end

    // Reset in the middle of a run
    for (int i = 0; i < VS; i++) xv[i] = rand_x();
    in_vec = pack_vec(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out", 32'(out_vec != '0), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(valid), 0);
    @(negedge clk);
    rst = 1'b1;
    vc = 0;
    repeat (35) begin
      @(negedge clk);
      vc += int'(valid);
    end
    check("post_rst_no_valid", vc, 0);
    check("post_rst_out", 32'(out_vec != '0), 0);
    for (int i = 0; i < VS; i++) xv[i] = rand_x();
    run_vec(0, lat, bc);
    check("fresh_latency", lat, 22);
    check_outputs("fresh_out", 0);

    // Four lanes
    xv = '{0, 128, 256, -256, 608, 1280, -1280, -524288, 0, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    run_vec(1, lat, bc);
    check("l4_latency", lat, 7);
    check("l4_busy_cycles", bc, 7);
    check_outputs("l4_out", 1);
    @(negedge clk);
    check("l4_valid_single", 32'(valid4), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
